// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_reg
//  Purpose  : MIPS32 coprocessor-0 register subset: BadVAddr, Count, Compare,
//             Status, Cause and EPC, with exception/ERET commit handling and
//             the interrupt request output.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk, rst                     clock, synchronous active-high reset
//    cp0_we_i/waddr_i/wdata_i     MTC0 write (select 0, addressed by rd)
//    cp0_raddr_i/cp0_rdata_o      MFC0 read, combinational, no write bypass
//    exc_flag_i/exc_type_i        committed exception (1..8) or ERET (9)
//    exc_pc_i/exc_bd_i/exc_baddr_i  faulting PC, delay-slot flag, bad address
//    ext_int_i                    level-sensitive hardware interrupt lines
//    cp0_epc_o, cp0_errorepc_o, cp0_status_o, cp0_cause_o, cp0_intr_o
//
//  Configuration
//    CP0_TIMER_EN  when defined, Count/Compare and the timer interrupt (TI)
//                  are built; COUNT_DIV (1 or 2) sets cycles per Count tick.
// ============================================================================
module cp0_reg #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  input  logic        exc_flag_i,
  input  logic [3:0]  exc_type_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_baddr_i,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] cp0_errorepc_o,
  output logic [31:0] cp0_status_o,
  output logic [31:0] cp0_cause_o,
  output logic        cp0_intr_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  if (COUNT_DIV != 1 && COUNT_DIV != 2) begin : g_count_div_check
    $error("cp0_reg: COUNT_DIV must be 1 or 2");
  end

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        ti;

  // Exception decode
  logic       exc_take, exc_eret, exc_badv;
  logic [4:0] exc_code;

  always_comb begin
    exc_take = 1'b0;
    exc_eret = 1'b0;
    exc_badv = 1'b0;
    exc_code = 5'd0;
    if (exc_flag_i) begin
      case (exc_type_i)
        4'd1: begin exc_take = 1'b1; exc_code = 5'd0;  end
        4'd2: begin exc_take = 1'b1; exc_code = 5'd4;  exc_badv = 1'b1; end
        4'd3: begin exc_take = 1'b1; exc_code = 5'd4;  exc_badv = 1'b1; end
        4'd4: begin exc_take = 1'b1; exc_code = 5'd5;  exc_badv = 1'b1; end
        4'd5: begin exc_take = 1'b1; exc_code = 5'd12; end
        4'd6: begin exc_take = 1'b1; exc_code = 5'd8;  end
        4'd7: begin exc_take = 1'b1; exc_code = 5'd9;  end
        4'd8: begin exc_take = 1'b1; exc_code = 5'd10; end
        4'd9: exc_eret = 1'b1;
        default: ;
      endcase
    end
  end

  logic we_status, we_cause, we_epc;
  assign we_status = cp0_we_i && (cp0_waddr_i == ADDR_STATUS);
  assign we_cause  = cp0_we_i && (cp0_waddr_i == ADDR_CAUSE);
  assign we_epc    = cp0_we_i && (cp0_waddr_i == ADDR_EPC);

  // MTC0 is applied first; exception fields then overwrite whatever they own.
  always_comb begin
    ie_d       = we_status ? cp0_wdata_i[0]    : ie_q;
    exl_d      = we_status ? cp0_wdata_i[1]    : exl_q;
    im_d       = we_status ? cp0_wdata_i[15:8] : im_q;
    ip_sw_d    = we_cause  ? cp0_wdata_i[9:8]  : ip_sw_q;
    epc_d      = we_epc    ? cp0_wdata_i       : epc_q;
    ip_hw_d    = ext_int_i;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    badvaddr_d = badvaddr_q;
    if (exc_take) begin
      exl_d     = 1'b1;
      exccode_d = exc_code;
      // A nested exception keeps the EPC/BD of the outer one.
      if (!exl_q) begin
        epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      if (exc_badv) badvaddr_d = exc_baddr_i;
    end else if (exc_eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        div_q, div_d;
  logic        tick;
  logic        we_count, we_compare;

  assign we_count   = cp0_we_i && (cp0_waddr_i == ADDR_COUNT);
  assign we_compare = cp0_we_i && (cp0_waddr_i == ADDR_COMPARE);

  always_comb begin
    tick      = (COUNT_DIV == 1) ? 1'b1 : div_q;
    div_d     = (COUNT_DIV == 1) ? 1'b0 : ~div_q;
    count_d   = tick ? (count_q + 32'd1) : count_q;
    if (we_count) count_d = cp0_wdata_i;
    compare_d = we_compare ? cp0_wdata_i : compare_q;
    ti_d      = ti_q;
    // Clearing by a Compare write has priority over a same-edge match.
    if (we_compare)
      ti_d = 1'b0;
    else if ((tick || we_count) && (count_d == compare_d))
      ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      div_q     <= div_d;
    end
  end

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  logic [7:0] ip;
  assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  assign cp0_status_o   = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cp0_cause_o    = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'd0};
  assign cp0_epc_o      = epc_q;
  assign cp0_errorepc_o = 32'd0;
  assign cp0_intr_o     = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    cp0_rdata_o = 32'd0;
    case (cp0_raddr_i)
      ADDR_BADVADDR: cp0_rdata_o = badvaddr_q;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:    cp0_rdata_o = count_q;
      ADDR_COMPARE:  cp0_rdata_o = compare_q;
`endif
      ADDR_STATUS:   cp0_rdata_o = cp0_status_o;
      ADDR_CAUSE:    cp0_rdata_o = cp0_cause_o;
      ADDR_EPC:      cp0_rdata_o = epc_q;
      default:       cp0_rdata_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have parameter COUNT_DIV, default 2, meaning cycles per Count increment; legal values are 1 or 2.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cp0_we_i in 1 and cp0_waddr_i in 5 and cp0_wdata_i in 32: MTC0 write, rd field select 0, addressed by rd number.
REQ-005 SHALL have ports cp0_raddr_i in 5 and cp0_rdata_o out 32: MFC0 read, combinational from current register state, no write bypass.
REQ-006 SHALL have ports exc_flag_i in 1 and exc_type_i in 4: committed exception/ERET from the exception stage; 1 Intr, 2 AdEL-fetch, 3 AdEL-data, 4 AdES, 5 Ov, 6 SysC, 7 Bp, 8 RI, 9 ERET.
REQ-007 SHALL have ports exc_pc_i in 32, exc_bd_i in 1 (instruction in branch delay slot) and exc_baddr_i in 32 (faulting address).
REQ-008 SHALL have port ext_int_i  in  6  hardware interrupt lines, level-sensitive, active-high.
REQ-009 SHALL have outputs cp0_epc_o 32, cp0_errorepc_o 32 (constant 0), cp0_status_o 32, cp0_cause_o 32, cp0_intr_o 1.

Function
REQ-010 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses read 0, writes to them are ignored.
REQ-011 Status SHALL hold BEV bit22 read-only 1, IM[15:8], EXL bit1, IE bit0; all other bits read 0 and ignore writes.
REQ-012 Cause SHALL hold BD bit31, TI bit30, IP[15:10] hardware, IP[9:8] software-writable, ExcCode[6:2]; only IP[9:8] is MTC0-writable.
REQ-013 Cause.IP[15:10] SHALL register ext_int_i each cycle, 1-cycle latency; IP[15] = ext_int_i[5] OR TI.
REQ-014 cp0_intr_o SHALL be combinational: Status.IE AND NOT Status.EXL AND OR(Cause.IP[15:8] AND Status.IM[15:8]).
REQ-015 On exc_flag_i with type 1..8: EXL<=1; ExcCode per type 0,4,4,5,12,8,9,10; if EXL was 0, EPC<=exc_bd_i ? exc_pc_i-4 : exc_pc_i and BD<=exc_bd_i; if EXL was 1, EPC and BD unchanged.
REQ-016 BadVAddr SHALL load exc_baddr_i only on types 2,3,4; unchanged otherwise.
REQ-017 On exc_flag_i with type 9 (ERET): EXL<=0, no other register changes.
REQ-018 exc_flag_i with type 0 or above 9 SHALL be ignored.
REQ-019 Same-cycle exception and MTC0: exception update SHALL win for every register field it writes; MTC0 applies to remaining fields only.
REQ-020 Write to Compare SHALL clear TI in the same edge; a write to Count SHALL replace the increment that cycle.
REQ-021 EPC and Count SHALL be fully writable, 32-bit, Count wraps 0xFFFF_FFFF -> 0.

Reset
REQ-022 On rst: Status=0x0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, divider phase=0; cp0_intr_o=0 in the cycle after reset.
REQ-023 rst SHALL override all same-cycle exception and MTC0 inputs.

Configuration
REQ-024 With CP0_TIMER_EN defined: Count increments once every COUNT_DIV cycles; when Count equals Compare after an update, TI<=1, held until Compare written or reset.
REQ-025 Without CP0_TIMER_EN: Count and Compare are absent, read 0, writes ignored, TI constant 0, IP[15]=ext_int_i[5] only.

Verification
REQ-026 Reset, read all six registers -> Status=0x0040_0000, all others 0, cp0_intr_o=0.
REQ-027 MTC0 Status=0x0000_0401, ext_int_i=6'b000001 -> cp0_intr_o=1 one cycle after ext_int_i asserts; exception type 1 at exc_pc_i=0x8000_0100 -> EPC=0x8000_0100, EXL=1, ExcCode=0, cp0_intr_o=0.
REQ-028 Type 3 with exc_bd_i=1, exc_pc_i=0xBFC0_0010, exc_baddr_i=0x0000_0003 -> EPC=0xBFC0_000C, BD=1, BadVAddr=0x3, ExcCode=4; then type 9 -> EXL=0, EPC unchanged.
REQ-029 Nested: type 5 while EXL=1 -> EPC unchanged, ExcCode=12.
REQ-030 CP0_TIMER_EN, COUNT_DIV=2: Compare=5, Count=0 -> TI=1 after 10 cycles; MTC0 Compare -> TI=0 next cycle; Count=0xFFFF_FFFF wraps to 0.
REQ-031 Same-cycle MTC0 Status=0 and type 6 -> EXL=1, IE=0, IM=0.
